// File: rtl/ddc_iq_pack_wr.sv
// ddc_iq_pack_wr
//   Packs DDC I/Q sample pairs, four per word, into the shared sample RAM
//   read by the PRI frame builder. Each PRI skips gate_delay valid samples
//   after the synchronised pri rising edge, then writes data_length words
//   starting at address 0.
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             level enable; low forces IDLE and drops any partial word
//   pri                PRI pulse (asynchronous, synchronised here)
//   data_length        words per PRI, latched at the pri edge
//   gate_delay         valid samples skipped after the pri edge, latched at the edge
//   ddc_i, ddc_q       sample pair, qualified by ddc_valid
//   ram_wr/addr/din    RAM write port, one strobe per packed word
//   pri_done           pulse with the last write of a PRI
//   pri_short          pulse when a new pri edge aborts an unfinished capture
module ddc_iq_pack_wr #(
  parameter int ADDR_W = 14,
  parameter int SAMP_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pri,
  input  logic [15:0]         data_length,
  input  logic [15:0]         gate_delay,
  input  logic [SAMP_W-1:0]   ddc_i,
  input  logic [SAMP_W-1:0]   ddc_q,
  input  logic                ddc_valid,
  output logic                ram_wr,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [8*SAMP_W-1:0] ram_din,
  output logic                pri_done,
  output logic                pri_short
);

  localparam int LANES = 4;
  localparam int LW    = 2*SAMP_W;
  localparam int CW    = ADDR_W + 1;   // word count must reach 2^ADDR_W

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GATE = 2'd1;
  localparam logic [1:0] S_PACK = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        p1, p2, p3;
  logic        rise;
  logic [1:0]  st;
  logic [CW-1:0] len_q, wcnt, len_clip;
  logic [15:0] gate_q, gcnt;
  logic [1:0]  lane;
  // lane_q[3] holds lane 0 so the packed vector lands MSB-first in ram_din
  logic [LANES-1:1][LW-1:0] lane_q;

  // three-flop chain: p1 is the metastability catcher, edge detect on p2/p3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0; p2 <= 1'b0; p3 <= 1'b0;
    end else begin
      p1 <= pri; p2 <= p1; p3 <= p2;
    end
  end
  assign rise = p2 & ~p3;

  // a PRI can never address more than the RAM holds
  always_comb begin
    len_clip = CW'(data_length);
    if (32'(data_length) > (32'd1 << ADDR_W)) len_clip = CW'(32'd1 << ADDR_W);
  end

  // lanes 0..2 are buffered; lane 3 goes straight into the write word
  for (genvar g = 1; g < LANES; g++) begin : g_lane
    logic [LW-1:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        q <= '0;
      else if (st == S_PACK && ddc_valid && lane == 2'(LANES-1-g))
        q <= {ddc_i, ddc_q};
    end
    assign lane_q[g] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      len_q     <= '0;
      gate_q    <= '0;
      gcnt      <= '0;
      wcnt      <= '0;
      lane      <= '0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      pri_done  <= 1'b0;
      pri_short <= 1'b0;
    end else begin
      ram_wr    <= 1'b0;
      pri_done  <= 1'b0;
      pri_short <= 1'b0;
      if (!enable) begin
        st       <= S_IDLE;
        ram_addr <= '0;
        lane     <= '0;
      end else if (rise) begin
        // re-arm from any state; an unfinished capture is flagged and dropped
        len_q     <= len_clip;
        gate_q    <= gate_delay;
        gcnt      <= '0;
        wcnt      <= '0;
        lane      <= '0;
        pri_short <= (st == S_GATE) || (st == S_PACK);
        if (gate_delay != 16'd0)   st <= S_GATE;
        else if (len_clip != '0)   st <= S_PACK;
        else                       st <= S_DONE;
      end else begin
        case (st)
          S_GATE: if (ddc_valid) begin
            gcnt <= gcnt + 16'd1;
            // the sample that completes the gate is itself dropped
            if (gcnt + 16'd1 == gate_q) st <= (len_q != '0) ? S_PACK : S_DONE;
          end
          S_PACK: if (ddc_valid) begin
            lane <= lane + 2'd1;
            if (lane == 2'(LANES-1)) begin
              ram_wr   <= 1'b1;
              ram_addr <= wcnt[ADDR_W-1:0];
              ram_din  <= {lane_q, ddc_i, ddc_q};
              wcnt     <= wcnt + CW'(1);
              if (wcnt + CW'(1) == len_q) begin
                pri_done <= 1'b1;
                st       <= S_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
